// File: rtl/uart_duplex.sv
// Full-duplex UART: independent TX and RX engines sharing one clock and framing parameters.
// Define UART_LOOPBACK_EN to add a loopback input that feeds the TX stream into RX.
module uart_duplex #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 uart_clk,
  input  logic                 reset,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_line,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 frame_error
);

  localparam int unsigned StopClks = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned TxCntW   = $clog2(StopClks);
  localparam int unsigned RxCntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW     = $clog2(DATA_BITS);
  localparam int unsigned HalfClks = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------- TX
  state_e                tx_state_q, tx_state_d;
  logic [TxCntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]       tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_ser_q, tx_ser_d;

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_ser_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_ser_q   <= tx_ser_d;
    end
  end

  // tx_ser_q is registered so the line changes exactly on bit boundaries, glitch-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_ser_d   = tx_ser_q;
    unique case (tx_state_q)
      StIdle: begin
        tx_ser_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (PARITY == 2) ? ^tx_data : ~^tx_data;
          tx_cnt_d   = '0;
          tx_ser_d   = 1'b0;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_cnt_q == TxCntW'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_ser_d   = tx_shift_q[0];
          tx_state_d = StData;
        end else begin
          tx_cnt_d = tx_cnt_q + TxCntW'(1);
        end
      end
      StData: begin
        if (tx_cnt_q == TxCntW'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BitW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_ser_d   = tx_par_q;
              tx_state_d = StParity;
            end else begin
              tx_ser_d   = 1'b1;
              tx_state_d = StStop;
            end
          end else begin
            tx_bit_d = tx_bit_q + BitW'(1);
            tx_ser_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + TxCntW'(1);
        end
      end
      StParity: begin
        if (tx_cnt_q == TxCntW'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d   = '0;
          tx_ser_d   = 1'b1;
          tx_state_d = StStop;
        end else begin
          tx_cnt_d = tx_cnt_q + TxCntW'(1);
        end
      end
      StStop: begin
        if (tx_cnt_q == TxCntW'(StopClks - 1)) begin
          tx_cnt_d   = '0;
          tx_ser_d   = 1'b1;
          tx_state_d = StIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + TxCntW'(1);
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  assign tx_ready = (tx_state_q == StIdle);

  // ---------------------------------------------------------------- loopback mux
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src  = loopback ? tx_ser_q : rx_line;
  assign tx_line = loopback ? 1'b1 : tx_ser_q;
`else
  assign rx_src  = rx_line;
  assign tx_line = tx_ser_q;
`endif

  // ---------------------------------------------------------------- RX
  state_e                rx_state_q, rx_state_d;
  logic [RxCntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_par_q, rx_par_d;
  logic                  rx_s1_q, rx_s2_q, rx_prev_q;
  logic                  rx_wait_q, rx_wait_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_wait_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_s1_q    <= rx_src;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_wait_q  <= rx_wait_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // rx_wait_q blocks start detection after a frame error until the line is seen high.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_wait_d  = rx_wait_q & ~rx_s2_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    unique case (rx_state_q)
      StIdle: begin
        if (!rx_wait_q && rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q == RxCntW'(HalfClks - 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s2_q ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + RxCntW'(1);
        end
      end
      StData: begin
        if (rx_cnt_q == RxCntW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BitW'(DATA_BITS - 1)) begin
            rx_state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            rx_bit_d = rx_bit_q + BitW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + RxCntW'(1);
        end
      end
      StParity: begin
        if (rx_cnt_q == RxCntW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s2_q;
          rx_state_d = StStop;
        end else begin
          rx_cnt_d = rx_cnt_q + RxCntW'(1);
        end
      end
      StStop: begin
        if (rx_cnt_q == RxCntW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = StIdle;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          perr_d     = (PARITY != 0) && ((^rx_shift_q ^ rx_par_q) != (PARITY == 1));
          ferr_d     = ~rx_s2_q;
          rx_wait_d  = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + RxCntW'(1);
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_uart_duplex.sv
// Scoreboard bench for uart_duplex (default framing: 4 clks/bit, 8 data, odd parity, 1 stop).
module tb_uart_duplex;
  localparam int CPB       = 4;
  localparam int NBITS     = 11;
  localparam int FRAME_CYC = NBITS * CPB;

  logic       uart_clk = 1'b0;
  logic       rst_n    = 1'b1;
  logic       tx_valid = 1'b0;
  logic       rx_line  = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, tx_line, rx_valid, parity_error, frame_error;
  logic [7:0] rx_data;
`ifdef UART_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [FRAME_CYC-1:0] tx_exp[$];
  logic [9:0]           rx_exp[$];  // {data, parity_error, frame_error}

  uart_duplex #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .PARITY      (1),
    .STOP_BITS   (1)
  ) dut (
    .uart_clk    (uart_clk),
    .reset       (rst_n),
`ifdef UART_LOOPBACK_EN
    .loopback    (loopback),
`endif
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_line     (tx_line),
    .rx_line     (rx_line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_error(parity_error),
    .frame_error (frame_error)
  );

  always #5 uart_clk = ~uart_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference framing: start 0, data LSB first, odd parity, stop 1.
  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d, input logic pflip,
                                                  input logic sbad);
    logic [NBITS-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = odd_par(d) ^ pflip;
    f[10] = ~sbad;
    return f;
  endfunction

  function automatic logic [FRAME_CYC-1:0] tx_wave(input logic [7:0] d);
    logic [NBITS-1:0]     f;
    logic [FRAME_CYC-1:0] w;
    f = frame_bits(d, 1'b0, 1'b0);
    for (int c = 0; c < FRAME_CYC; c++) w[c] = f[c / CPB];
    return w;
  endfunction

  task automatic send_tx(input logic [7:0] d, input bit on_line);
    int waited = 0;
    @(posedge uart_clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 500) begin
      @(posedge uart_clk); #1;
      waited++;
    end
    if (!tx_ready) begin
      chk("tx_accept_timeout", tx_ready, 1);
      tx_valid = 1'b0;
    end else begin
      @(posedge uart_clk); #1;
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);  // must not disturb the frame in flight
      if (on_line) tx_exp.push_back(tx_wave(d));
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pflip, input logic sbad,
                         input int hold_low);
    logic [NBITS-1:0] f;
    f = frame_bits(d, pflip, sbad);
    rx_exp.push_back({d, pflip, sbad});
    @(posedge uart_clk); #1;
    for (int k = 0; k < NBITS; k++) begin
      rx_line = f[k];
      repeat (CPB) @(posedge uart_clk);
      #1;
    end
    if (hold_low > 0) begin
      rx_line = 1'b0;
      repeat (hold_low) @(posedge uart_clk);
      #1;
    end
    rx_line = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < 3000) begin
      @(posedge uart_clk);
      n++;
    end
    repeat (FRAME_CYC + 10) @(posedge uart_clk);
    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("rx_queue_drained", rx_exp.size(), 0);
  endtask

  // TX monitor: any low on tx_line opens a frame, compared cycle by cycle to the model.
  initial begin : tx_mon
    logic [FRAME_CYC-1:0] obs, exp;
    int  low_rdy;
    bit  aborted;
    forever begin
      @(negedge uart_clk);
      if (rst_n && tx_line == 1'b0) begin
        if (tx_exp.size() == 0) begin
          chk("tx_unexpected_start", tx_line, 1);
        end else begin
          exp     = tx_exp.pop_front();
          obs     = '0;
          low_rdy = 0;
          aborted = 0;
          for (int i = 0; i < FRAME_CYC; i++) begin
            if (i > 0) @(negedge uart_clk);
            if (!rst_n) begin
              aborted = 1;
              break;
            end
            obs[i] = tx_line;
            if (!tx_ready) low_rdy++;
          end
          if (!aborted) begin
            chk("tx_frame", obs, exp);
            chk("tx_ready_low_cycles", low_rdy, FRAME_CYC);
            @(negedge uart_clk);
            if (rst_n) chk("tx_ready_after_stop", tx_ready, 1);
          end
        end
      end
    end
  end

  // RX monitor: every rx_valid pulse consumes one expected word.
  initial begin : rx_mon
    logic [9:0] e;
    forever begin
      @(negedge uart_clk);
      if (rx_valid) begin
        if (rx_exp.size() == 0) begin
          chk("rx_unexpected_valid", rx_valid, 0);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_data", rx_data, e[9:2]);
          chk("rx_parity_error", parity_error, e[1]);
          chk("rx_frame_error", frame_error, e[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx_line", tx_line, 1);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_parity_error", parity_error, 0);
    chk("reset_frame_error", frame_error, 0);
    repeat (3) @(posedge uart_clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge uart_clk);

    // Directed: the 0x6B frame both ways at once.
    fork
      send_tx(8'h6B, 1'b1);
      send_rx(8'h6B, 1'b0, 1'b0, 0);
    join
    send_rx(8'h6B, 1'b1, 1'b0, 0);   // bad parity
    send_rx(8'h6B, 1'b0, 1'b1, 20);  // bad stop, line held low afterwards
    repeat (3) @(posedge uart_clk);
    send_rx(8'h0F, 1'b0, 1'b0, 0);
    @(posedge uart_clk); #1 rx_line = 1'b0;  // one-cycle glitch
    @(posedge uart_clk); #1 rx_line = 1'b1;
    repeat (8) @(posedge uart_clk);
    send_rx(8'hA5, 1'b0, 1'b0, 0);
    drain();

    // Random concurrent traffic.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send_tx(8'($urandom), 1'b1);
          repeat ($urandom_range(0, 3)) @(posedge uart_clk);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          logic pf, sb;
          pf = ($urandom_range(0, 3) == 0);
          sb = ($urandom_range(0, 7) == 0);
          send_rx(8'($urandom), pf, sb, 0);
          repeat ($urandom_range(0, 4) + (sb ? 2 : 0)) @(posedge uart_clk);
        end
      end
    join
    drain();

    // Reset in the middle of a TX frame and a partial RX frame.
    send_tx(8'h5A, 1'b1);
    rx_line = 1'b0;
    repeat (9) @(posedge uart_clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_tx_line", tx_line, 1);
    chk("midreset_tx_ready", tx_ready, 1);
    chk("midreset_rx_data", rx_data, 0);
    chk("midreset_frame_error", frame_error, 0);
    rx_line = 1'b1;
    repeat (3) @(posedge uart_clk);
    #1 rst_n = 1'b1;
    #1;
    chk("postreset_tx_ready", tx_ready, 1);
    repeat (FRAME_CYC + 10) @(posedge uart_clk);
    fork
      send_tx(8'hC3, 1'b1);
      send_rx(8'h81, 1'b0, 1'b0, 0);
    join
    drain();

`ifdef UART_LOOPBACK_EN
    loopback = 1'b1;
    rx_exp.push_back({8'h3C, 1'b0, 1'b0});
    send_tx(8'h3C, 1'b0);
    repeat (FRAME_CYC + 10) @(posedge uart_clk);
    loopback = 1'b0;
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
